// File: rtl/act_stream_serializer.sv
// rtl/act_stream_serializer.sv - queues wide activation vectors and replays them one word per beat
module act_stream_serializer #(
   parameter int BITWIDTH     = 16,
   parameter int NFMAPS       = 16,
   parameter int DEPTH        = 4,
   parameter int FRAME_PIXELS = 25
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [NFMAPS*BITWIDTH-1:0] in_act,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [BITWIDTH-1:0]        m_data,
   output logic                       m_last,
   output logic                       overflow
);
   localparam int VW = NFMAPS * BITWIDTH;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WI = (NFMAPS > 1) ? $clog2(NFMAPS) : 1;
   localparam int PW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [WI-1:0] LAST_W = WI'(NFMAPS - 1);
   localparam logic [PW-1:0] LAST_P = PW'(FRAME_PIXELS - 1);

   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;

   logic [VW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, rd_inc;
   logic [CW-1:0]       count, count_nxt;
   logic [WI-1:0]       word_idx, word_nxt, word_inc;
   logic [PW-1:0]       pix_idx, pix_nxt, pix_wrap;
   logic [BITWIDTH-1:0] m_data_nxt;
   logic                m_valid_nxt, m_last_nxt, overflow_nxt;
   logic                hs, last_word, release_c, wr_en;

   function automatic logic [BITWIDTH-1:0] pick(input logic [VW-1:0] v, input logic [WI-1:0] k);
      return v[int'(k)*BITWIDTH +: BITWIDTH];
   endfunction

   function automatic logic is_last(input logic [WI-1:0] w, input logic [PW-1:0] p);
      return (w == LAST_W) && (p == LAST_P);
   endfunction

   assign hs        = m_valid & m_ready;
   assign last_word = (word_idx == LAST_W);
   assign release_c = (state == SEND) & hs & last_word;
   // A finishing vector frees its slot in the same cycle, so a full queue can still accept.
   assign wr_en     = ~flush & in_valid & ((count != FULL) | release_c);
   assign rd_inc    = rd_ptr + AW'(1);
   assign word_inc  = word_idx + WI'(1);
   assign pix_wrap  = (pix_idx == LAST_P) ? '0 : pix_idx + PW'(1);

   always_comb begin
      state_nxt    = state;
      rd_ptr_nxt   = rd_ptr;
      wr_ptr_nxt   = wr_en ? wr_ptr + AW'(1) : wr_ptr;
      count_nxt    = count + CW'(wr_en) - CW'(release_c);
      overflow_nxt = overflow | (in_valid & (count == FULL) & ~release_c);
      word_nxt     = word_idx;
      pix_nxt      = pix_idx;
      m_valid_nxt  = m_valid;
      m_data_nxt   = m_data;
      m_last_nxt   = m_last;

      case (state)
         IDLE: begin
            if (count != '0) begin
               m_data_nxt  = pick(mem[rd_ptr], '0);
               m_last_nxt  = is_last('0, pix_idx);
               m_valid_nxt = 1'b1;
               state_nxt   = SEND;
            end
         end
         SEND: begin
            if (hs && !last_word) begin
               word_nxt   = word_inc;
               m_data_nxt = pick(mem[rd_ptr], word_inc);
               m_last_nxt = is_last(word_inc, pix_idx);
            end else if (hs) begin
               rd_ptr_nxt = rd_inc;
               word_nxt   = '0;
               pix_nxt    = pix_wrap;
               m_last_nxt = is_last('0, pix_wrap);
               // With one entry left, the next vector may be the one arriving right now.
               if (count > CW'(1)) begin
                  m_data_nxt = pick(mem[rd_inc], '0);
               end else if (wr_en) begin
                  m_data_nxt = pick(in_act, '0);
               end else begin
                  m_valid_nxt = 1'b0;
                  m_last_nxt  = 1'b0;
                  state_nxt   = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (flush) begin
         state_nxt    = IDLE;
         rd_ptr_nxt   = '0;
         wr_ptr_nxt   = '0;
         count_nxt    = '0;
         overflow_nxt = 1'b0;
         word_nxt     = '0;
         pix_nxt      = '0;
         m_valid_nxt  = 1'b0;
         m_last_nxt   = 1'b0;
         m_data_nxt   = m_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         word_idx <= '0;
         pix_idx  <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_ptr   <= rd_ptr_nxt;
         wr_ptr   <= wr_ptr_nxt;
         count    <= count_nxt;
         overflow <= overflow_nxt;
         word_idx <= word_nxt;
         pix_idx  <= pix_nxt;
         m_valid  <= m_valid_nxt;
         m_data   <= m_data_nxt;
         m_last   <= m_last_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_act;
      end
   end
endmodule

// File: tb/tb_act_stream_serializer.sv
// tb/tb_act_stream_serializer.sv - directed self-checking bench for act_stream_serializer
module tb_act_stream_serializer;
   localparam int BW = 16;
   localparam int NF = 16;
   localparam int FP = 25;

   typedef struct {
      logic          in_valid;
      logic          m_ready;
      logic          exp_valid;
      logic [BW-1:0] exp_data;
      logic          exp_last;
      logic          exp_ovf;
   } row_t;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             m_ready = 1'b0;
   logic [NF*BW-1:0] in_act = '0;
   logic             m_valid, m_last, overflow;
   logic [BW-1:0]    m_data;

   int          checks = 0;
   int          errors = 0;
   int          exp_pix = 0;
   int          beats = 0;
   int          lasts = 0;
   logic [BW:0] exp_q[$];
   row_t        tbl[18];

   act_stream_serializer #(
      .BITWIDTH(BW), .NFMAPS(NF), .DEPTH(4), .FRAME_PIXELS(FP)
   ) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_act(in_act),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [BW-1:0] wd(input int id, input int k);
      return 16'(id * 256 + k);
   endfunction

   function automatic logic [NF*BW-1:0] vec(input int id);
      logic [NF*BW-1:0] v;
      for (int k = 0; k < NF; k++) v[k*BW +: BW] = wd(id, k);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id);
      logic l;
      for (int k = 0; k < NF; k++) begin
         l = (k == NF - 1) && (exp_pix == FP - 1);
         exp_q.push_back({l, wd(id, k)});
      end
      exp_pix = (exp_pix == FP - 1) ? 0 : exp_pix + 1;
   endtask

   // One clock: score the beat taken at this edge and confirm stalled beats stay put.
   task automatic tick();
      logic [BW:0]   e;
      logic          hold, l0;
      logic [BW-1:0] d0;
      hold = m_valid && !m_ready && !flush;
      d0 = m_data;
      l0 = m_last;
      if (m_valid && m_ready && !flush) begin
         beats++;
         if (m_last) lasts++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got %0h, expected no beat", m_data);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e[BW-1:0]);
            chk("beat_last", m_last, e[BW]);
         end
      end
      @(posedge clk);
      #1;
      if (hold) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data", m_data, d0);
         chk("hold_last", m_last, l0);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   task automatic do_flush();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      exp_pix = 0;
   endtask

   task automatic wait_word(input string name, input logic [BW-1:0] target, input int budget);
      int n = 0;
      while (!(m_valid && m_data == target) && n < budget) begin
         tick();
         n++;
      end
      chk(name, m_valid && m_data == target, 1);
   endtask

   task automatic send_frame(input int first_id);
      m_ready = 1'b1;
      for (int v = 0; v < FP; v++) begin
         in_act = vec(first_id + v);
         in_valid = 1'b1;
         push_exp(first_id + v);
         tick();
         in_valid = 1'b0;
         repeat (15) tick();
      end
      drain(100);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_last", m_last, 0);
      chk("rst_ovf", overflow, 0);
      rstn = 1'b1;

      // Single vector: two-cycle latency then 16 consecutive words
      tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0};
      for (int i = 2; i < 17; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 16'(16'h1000 + i - 1), 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};
      in_act = vec(16);
      for (int i = 0; i < 18; i++) begin
         in_valid = tbl[i].in_valid;
         m_ready = tbl[i].m_ready;
         @(posedge clk);
         #1;
         chk($sformatf("t1_valid_%0d", i), m_valid, tbl[i].exp_valid);
         if (tbl[i].exp_valid) begin
            chk($sformatf("t1_data_%0d", i), m_data, tbl[i].exp_data);
            chk($sformatf("t1_last_%0d", i), m_last, tbl[i].exp_last);
         end
         chk($sformatf("t1_ovf_%0d", i), overflow, tbl[i].exp_ovf);
      end
      in_valid = 1'b0;

      // Full frame: m_last only on beat 400
      do_flush();
      beats = 0;
      lasts = 0;
      send_frame(100);
      chk("t2_beats", beats, 400);
      chk("t2_lasts", lasts, 1);
      chk("t2_ovf", overflow, 0);

      // Stalled sink: 4 kept, 2 dropped
      do_flush();
      m_ready = 1'b0;
      for (int v = 0; v < 6; v++) begin
         in_act = vec(40 + v);
         in_valid = 1'b1;
         if (v < 4) push_exp(40 + v);
         tick();
         in_valid = 1'b0;
         repeat (9) tick();
      end
      repeat (40) tick();
      chk("t3_ovf", overflow, 1);
      chk("t3_head", m_data, wd(40, 0));
      beats = 0;
      m_ready = 1'b1;
      drain(200);
      chk("t3_beats", beats, 64);
      repeat (2) tick();
      chk("t3_idle", m_valid, 0);
      chk("t3_ovf_sticky", overflow, 1);

      // Toggling ready
      do_flush();
      chk("t4_flush_ovf", overflow, 0);
      for (int c = 0; c < 120; c++) begin
         m_ready = (c % 2 == 0);
         in_valid = (c == 0 || c == 8 || c == 16);
         if (in_valid) begin
            in_act = vec(60 + c / 8);
            push_exp(60 + c / 8);
         end
         tick();
      end
      in_valid = 1'b0;
      m_ready = 1'b1;
      drain(100);
      chk("t4_ovf", overflow, 0);

      // Full queue accepts on the release cycle; single entry hands over without a bubble
      do_flush();
      m_ready = 1'b0;
      for (int v = 0; v < 4; v++) begin
         in_act = vec(70 + v);
         in_valid = 1'b1;
         push_exp(70 + v);
         tick();
         in_valid = 1'b0;
         tick();
      end
      repeat (4) tick();
      chk("t5_ovf_full", overflow, 0);
      m_ready = 1'b1;
      wait_word("t5_wait_last", wd(70, 15), 40);
      in_act = vec(74);
      in_valid = 1'b1;
      push_exp(74);
      tick();
      in_valid = 1'b0;
      chk("t5_ovf_release", overflow, 0);
      chk("t5_next_valid", m_valid, 1);
      chk("t5_next_head", m_data, wd(71, 0));
      wait_word("t5_wait_single", wd(74, 15), 100);
      in_act = vec(75);
      in_valid = 1'b1;
      push_exp(75);
      tick();
      in_valid = 1'b0;
      chk("t5_bypass_valid", m_valid, 1);
      chk("t5_bypass_data", m_data, wd(75, 0));
      drain(60);
      chk("t5_ovf_end", overflow, 0);

      // Flush mid-vector (word 7 of pix 3), with overflow set beforehand
      do_flush();
      m_ready = 1'b0;
      for (int v = 0; v < 5; v++) begin
         in_act = vec(80 + v);
         in_valid = 1'b1;
         if (v < 4) push_exp(80 + v);
         tick();
         in_valid = 1'b0;
         tick();
      end
      chk("t6_ovf_set", overflow, 1);
      m_ready = 1'b1;
      wait_word("t6_wait_mid", wd(83, 7), 100);
      m_ready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_valid", m_valid, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_last", m_last, 0);
      chk("t6_data_kept", m_data, wd(83, 7));
      exp_q.delete();
      exp_pix = 0;
      beats = 0;
      lasts = 0;
      send_frame(90);
      chk("t6_beats", beats, 400);
      chk("t6_lasts", lasts, 1);

      // Asynchronous reset mid-operation
      m_ready = 1'b0;
      in_act = vec(125);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("t7_pre_valid", m_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t7_async_valid", m_valid, 0);
      chk("t7_async_data", m_data, 0);
      chk("t7_async_last", m_last, 0);
      @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
